// File: rtl/recolector_pkg.sv
`default_nettype none
// ============================================================================
// Module   : recolector_pkg
// Purpose  : Shared definitions for the output side of the 4x4 FIFO switch:
//            FSM state encodings, destination-field slice helpers and small
//            port-index utilities. The routing arbiter reuses the same items.
// Revision : 1.0 - initial release
// ============================================================================
package recolector_pkg;

    // Reader FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CAPT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam int NPORTS = 4;
    localparam int DEST_W = 2;

    // Destination field occupies the two MSBs of every word
    function automatic int dest_hi(input int width);
        return width - 1;
    endfunction

    function automatic int dest_lo(input int width);
        return width - DEST_W;
    endfunction

    // Port that gets top priority after serving port p
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return p + 2'd1;
    endfunction

    function automatic logic [3:0] port_onehot(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

endpackage : recolector_pkg
`default_nettype wire

// File: rtl/recolector_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_select
// Purpose  : Combinational 4-way rotating-priority finder. Starting at rr_i,
//            scans rr_i, rr_i+1, rr_i+2, rr_i+3 (mod 4) and reports the first
//            requesting index.
// Ports    : req_i   - per-port request (non-empty) bits
//            rr_i    - index with highest priority
//            found_o - at least one request present
//            sel_o   - selected index (rr_i when nothing is found)
// Revision : 1.0 - initial release
// ============================================================================
module rr_select (
    input  logic [3:0] req_i,
    input  logic [1:0] rr_i,
    output logic       found_o,
    output logic [1:0] sel_o
);

    logic [1:0] idx;

    always_comb begin
        found_o = 1'b0;
        sel_o   = rr_i;
        idx     = rr_i;
        for (int i = 0; i < 4; i++) begin
            // 2-bit addition wraps the scan around port 3 -> port 0
            idx = rr_i + 2'(i);
            if (!found_o && req_i[idx]) begin
                found_o = 1'b1;
                sel_o   = idx;
            end
        end
    end

endmodule : rr_select
`default_nettype wire

// File: rtl/recolector.sv
`default_nettype none
// ============================================================================
// Module   : recolector
// Purpose  : Output-side reader of the 4x4 FIFO switch. Drains FIFOs 4..7 in
//            round-robin order (IDLE -> POP -> CAPT -> HOLD), checks each
//            word's destination field against its source port and delivers
//            every word on a single valid/ready stream.
// Ports    : clk, reset (async, active-low)
//            fifoN_out / fifoN_empty - read data and empty flag of FIFO N
//            popN                    - one-cycle pop strobe to FIFO N
//            data_out / port_out     - captured word and its source (0..3)
//            valid_out / ready_in    - downstream handshake
//            err_dest                - one-cycle pulse on destination mismatch
//            err_count               - saturating mismatch count
//            cnt4..cnt7              - wrapping per-port delivered-word counts
// Revision : 1.0 - initial release
// ============================================================================
module recolector
    import recolector_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] fifo4_out,
    input  logic [WIDTH-1:0] fifo5_out,
    input  logic [WIDTH-1:0] fifo6_out,
    input  logic [WIDTH-1:0] fifo7_out,
    input  logic             fifo4_empty,
    input  logic             fifo5_empty,
    input  logic             fifo6_empty,
    input  logic             fifo7_empty,
    output logic             pop4,
    output logic             pop5,
    output logic             pop6,
    output logic             pop7,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       port_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             err_dest,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] cnt4,
    output logic [CNT_W-1:0] cnt5,
    output logic [CNT_W-1:0] cnt6,
    output logic [CNT_W-1:0] cnt7
);

    localparam int               DEST_HI = dest_hi(WIDTH);
    localparam int               DEST_LO = dest_lo(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Vectorised view of ports 4..7 (index 0 = FIFO4)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] fifo_data [NPORTS];
    logic [3:0]       avail;

    assign fifo_data[0] = fifo4_out;
    assign fifo_data[1] = fifo5_out;
    assign fifo_data[2] = fifo6_out;
    assign fifo_data[3] = fifo7_out;
    assign avail        = ~{fifo7_empty, fifo6_empty, fifo5_empty, fifo4_empty};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [1:0]       rr_q;
    logic [1:0]       sel_q;
    logic [3:0]       pop_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       port_q;
    logic             valid_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] cnt_q [NPORTS];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             found;
    logic [1:0]       scan_sel;
    logic [WIDTH-1:0] rd_word;
    logic             mismatch;
    logic [CNT_W-1:0] err_cnt_d;
    logic [CNT_W-1:0] cnt_sel_d;

    rr_select u_rr_select (
        .req_i   (avail),
        .rr_i    (rr_q),
        .found_o (found),
        .sel_o   (scan_sel)
    );

    // Read data is valid in the CAPT cycle (one cycle after the pop)
    assign rd_word   = fifo_data[sel_q];
    assign mismatch  = (rd_word[DEST_HI:DEST_LO] != sel_q);
    assign err_cnt_d = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q : err_cnt_q + CNT_ONE;
    assign cnt_sel_d = cnt_q[sel_q] + CNT_ONE;

    // ------------------------------------------------------------------
    // Reader FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rr_q      <= 2'd0;
            sel_q     <= 2'd0;
            pop_q     <= 4'b0000;
            data_q    <= '0;
            port_q    <= 2'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        sel_q   <= scan_sel;
                        pop_q   <= port_onehot(scan_sel);
                        state_q <= ST_POP;
                    end
                end
                ST_POP: begin
                    pop_q   <= 4'b0000;
                    state_q <= ST_CAPT;
                end
                ST_CAPT: begin
                    data_q  <= rd_word;
                    port_q  <= sel_q;
                    valid_q <= 1'b1;
                    // Mismatched words are still delivered; only flagged here
                    if (mismatch) begin
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                    end
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (ready_in) begin
                        valid_q      <= 1'b0;
                        cnt_q[sel_q] <= cnt_sel_d;
                        rr_q         <= rr_next(sel_q);
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pop4      = pop_q[0];
    assign pop5      = pop_q[1];
    assign pop6      = pop_q[2];
    assign pop7      = pop_q[3];
    assign data_out  = data_q;
    assign port_out  = port_q;
    assign valid_out = valid_q;
    assign err_dest  = err_q;
    assign err_count = err_cnt_q;
    assign cnt4      = cnt_q[0];
    assign cnt5      = cnt_q[1];
    assign cnt6      = cnt_q[2];
    assign cnt7      = cnt_q[3];

endmodule : recolector
`default_nettype wire

// File: doc/recolector.md
# recolector

Output-side reader for the 4×4 FIFO switch. It drains the four output FIFOs (ports 4–7) in round-robin order and checks that each word's destination field matches the port it came from. Accepted words are serialized onto a single valid/ready stream for the downstream sink. This is the consumer counterpart of the push-driven input side: it generates `pop4..pop7` and is the only agent that empties FIFO4–FIFO7.

## Interface
- `WIDTH`, default 10: word width; `[WIDTH-1:WIDTH-2]` is the destination, `[WIDTH-3:0]` is the payload.
- `CNT_W`, default 8: width of the per-port word counters and the error counter.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low; asserting it forces every register to its reset value immediately.
- `fifo4_out`..`fifo7_out`, in, WIDTH each: read data of output FIFOs 4..7.
- `fifo4_empty`..`fifo7_empty`, in, 1 each: empty flags of FIFOs 4..7.
- `pop4`..`pop7`, out, 1 each: pop strobes, at most one high per cycle.
- `data_out`, out, WIDTH: captured word.
- `port_out`, out, 2: source port of `data_out` (0 = FIFO4 … 3 = FIFO7).
- `valid_out`, out, 1: `data_out`/`port_out` valid.
- `ready_in`, in, 1: downstream accepts when `valid_out && ready_in`.
- `err_dest`, out, 1: one-cycle pulse when a captured word's destination ≠ `port_out`.
- `err_count`, out, CNT_W: saturating count of destination mismatches.
- `cnt4`..`cnt7`, out, CNT_W each: words accepted downstream per port; wrap modulo 2^CNT_W.

## Operation
- FSM states: IDLE, POP, CAPT, HOLD. Round-robin pointer `rr` (2 bits) names the next port to check first.
- IDLE:
  - Scan ports `rr, rr+1, rr+2, rr+3` (mod 4) and select the first non-empty one.
  - If one is found, latch `sel` and go to POP. Otherwise stay in IDLE.
- POP:
  - Assert `pop[sel]` for exactly one cycle, then go to CAPT.
- CAPT:
  - Register `fifo[sel]_out` into `data_out` and `sel` into `port_out`.
  - Set `valid_out`. Pulse `err_dest` if `fifo[sel]_out[WIDTH-1:WIDTH-2] != sel`; increment `err_count` in the same cycle, saturating at all-ones.
  - Go to HOLD.
- HOLD:
  - Hold `valid_out`, `data_out` and `port_out` stable until `ready_in`.
  - On handshake: clear `valid_out`, increment `cnt[sel]`, set `rr = sel+1`, go to IDLE.
- Mismatched words are still delivered. `err_dest` only flags them.
- An empty flag that rises between IDLE selection and POP is impossible, because this block is the only popper. No recheck is made.
- Reset values: FSM in IDLE, `rr = 0`, all `pop* = 0`, `valid_out = 0`, `data_out = 0`, `port_out = 0`, `err_dest = 0`, `err_count = 0`, `cnt4..cnt7 = 0`.
- Reset mid-transfer: a word already popped but not handed off is discarded. Its FIFO entry is gone and no counter is updated.

## Timing
- FIFO read latency is 1 cycle. With `pop` high in cycle N, valid read data is sampled in cycle N+1 (the CAPT cycle).
- Sequence from a non-empty FIFO with the block in IDLE:
  - cycle 0: IDLE selects the port.
  - cycle 1: POP, `pop` high.
  - cycle 2: CAPT.
  - cycle 3 onward: HOLD, `valid_out` high from the edge ending CAPT.
- With `ready_in` held high, throughput is one word per 4 cycles.
- `err_dest` goes high on the same edge that sets `valid_out` and lasts one cycle.
- `pop*` are registered, Moore outputs of POP.
- Simultaneous non-empty ports: strict rotation. After serving port k, port k+1 has the highest priority.
- Counter wrap: `cnt*` rolls over from 2^CNT_W−1 to 0. `err_count` holds at 2^CNT_W−1.

## Structure
- Shared package/header holds:
  - FSM state encodings: IDLE=0, POP=1, CAPT=2, HOLD=3.
  - The destination field slice, `DEST_HI = WIDTH-1`, `DEST_LO = WIDTH-2`.
  - The same constants are reused by the routing arbiter.
- Sub-module `rr_select`: combinational 4-way rotate-priority finder. Inputs are the four `!empty` bits and `rr`; outputs are `found` and `sel[1:0]`.
- Ports 4..7 are internally vectorized, with a 4:1 read mux on `sel`.

## Test plan
- Reset and idle:
  - Drive `reset` low mid-run: all outputs go to their reset values asynchronously.
  - All FIFOs empty: no `pop*` asserted over 20 cycles.
- Single word:
  - FIFO5 holds `10'h1A5` (dest=1), `ready_in=1`: `pop5` in cycle 1; `data_out=10'h1A5`, `port_out=1`, `valid_out` in cycle 3; `cnt5=1`; `err_dest` never asserted.
- Round-robin:
  - All four FIFOs hold 2 correct words each, `rr=0`: pop order is 4,5,6,7,4,5,6,7.
  - Final counts: `cnt4..cnt7 = 2` each.
- Backpressure:
  - Hold `ready_in=0` for 10 cycles after `valid_out`: `data_out` is stable, no further `pop*`.
  - Release `ready_in`: handshake completes and the next pop follows 1 cycle later.
- Mismatch:
  - FIFO6 holds `10'h0FF` (dest=0): `err_dest` pulses once, `err_count=1`, word still delivered with `port_out=2`.
  - 300 mismatches: `err_count` saturates at 255.
- Reset mid-operation:
  - Assert reset during HOLD: `valid_out=0`, all counters=0.
  - After release the next word comes from the next non-empty FIFO scanned from port 4.
